// File: rtl/cmd_word_assembler.sv
// cmd_word_assembler
// Pops byte pairs from the command FIFO and assembles them into 16-bit command
// words for the slow-control decoder bus. A half-received command is dropped if
// the second byte does not arrive in time, and the loss is flagged with a strobe.
module cmd_word_assembler #(
    parameter int HI_FIRST       = 1,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   Clk_In,
    input  logic                   Rst_N,
    input  logic                   Fifo_Empty,
    input  logic [7:0]             Fifo_Dout,
    output logic                   Fifo_Rd_En,
    input  logic                   Cmd_Hold,
    output logic [16:1]            Cmd,
    output logic                   Cmd_En,
    output logic                   Timeout_Err,
    output logic [COUNT_WIDTH-1:0] Cmd_Count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_B0 = 2'd1;
    localparam logic [1:0] ST_NEED_B1 = 2'd2;
    localparam logic [1:0] ST_WAIT_B1 = 2'd3;

    // The timer counts up to TIMEOUT_CYCLES-1; the last step is taken in the
    // same cycle the timeout is declared, so the compare value is one lower.
    localparam int              TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);

    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [7:0]             byte0_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic [15:0]            cmd_reg;
    logic                   cmd_en_reg;
    logic                   timeout_err_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   rd_en_next;
    logic                   timer_expired;
    logic [15:0]            word_next;

    assign timer_expired = (timer_reg == TIMER_LAST);

    // Byte placement is fixed at elaboration time.
    generate
        if (HI_FIRST != 0) begin : g_hi_first
            assign word_next = {byte0_reg, Fifo_Dout};
        end else begin : g_lo_first
            assign word_next = {Fifo_Dout, byte0_reg};
        end
    endgenerate

    // Next-state and FIFO pop decode; the timeout takes priority over a byte
    // arriving in the same cycle, which leaves that byte for the next command.
    always_comb begin
        state_next = state_reg;
        rd_en_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!Fifo_Empty && !Cmd_Hold) begin
                    rd_en_next = 1'b1;
                    state_next = ST_WAIT_B0;
                end
            end
            ST_WAIT_B0: state_next = ST_NEED_B1;
            ST_NEED_B1: begin
                if (timer_expired) begin
                    state_next = ST_IDLE;
                end else if (!Fifo_Empty) begin
                    rd_en_next = 1'b1;
                    state_next = ST_WAIT_B1;
                end
            end
            ST_WAIT_B1: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Pops are suppressed while reset is held so the FIFO is never drained
    // by a design that is not listening.
    assign Fifo_Rd_En = Rst_N & rd_en_next;

    // State register.
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // First-byte capture and inter-byte idle timer.
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            byte0_reg <= 8'h00;
            timer_reg <= '0;
        end else if (state_reg == ST_WAIT_B0) begin
            byte0_reg <= Fifo_Dout;
            timer_reg <= '0;
        end else if (state_reg == ST_NEED_B1 && Fifo_Empty && !timer_expired) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    // Command word, strobe and running count; Cmd keeps its last value.
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            cmd_reg    <= 16'h0000;
            cmd_en_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            cmd_en_reg <= 1'b0;
            if (state_reg == ST_WAIT_B1) begin
                cmd_reg    <= word_next;
                cmd_en_reg <= 1'b1;
                count_reg  <= count_reg + 1'b1;
            end
        end
    end

    // One-cycle loss flag when a partial command is abandoned.
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= (state_reg == ST_NEED_B1) && timer_expired;
        end
    end

    assign Cmd         = cmd_reg;
    assign Cmd_En      = cmd_en_reg;
    assign Timeout_Err = timeout_err_reg;
    assign Cmd_Count   = count_reg;

endmodule

// File: tb/tb_cmd_word_assembler.sv
// tb_cmd_word_assembler
// Two instances (high-byte-first and low-byte-first) see identical FIFO traffic.
// Expected events go into a shared queue at push time; a monitor compares them.
module tb_cmd_word_assembler;

    localparam int NL     = 2;
    localparam int TO_CYC = 8;
    localparam int CW     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cmd_hold;
    logic          fifo_empty [NL];
    logic [7:0]    fifo_dout  [NL];
    logic          fifo_rd_en [NL];
    logic [15:0]   cmd_w      [NL];
    logic          cmd_en     [NL];
    logic          to_err     [NL];
    logic [CW-1:0] cmd_cnt    [NL];

    logic [7:0] byte_mem [0:511];
    int         wr_n = 0;
    int         rd_n [NL] = '{0, 0};
    int         cyc = 0;
    int         pop_cyc [NL][0:511];
    int         pop_n [NL] = '{0, 0};

    typedef struct {
        bit            is_to;
        logic [15:0]   v_hi;
        logic [15:0]   v_lo;
        logic [CW-1:0] cnt;
        int            idx;
    } ev_t;

    ev_t           exp_q [$];
    int            rd_ptr [NL] = '{0, 0};
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] model_cnt;
    logic [15:0]   last_cmd [NL];
    logic [CW-1:0] last_cnt [NL];
    logic          prev_rd [NL];
    ev_t           mon_ev;
    logic [15:0]   mon_val;
    int            mon_exp_c;

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        cmd_word_assembler #(
            .HI_FIRST      ((gi == 0) ? 1 : 0),
            .TIMEOUT_CYCLES(TO_CYC),
            .COUNT_WIDTH   (CW)
        ) u_dut (
            .Clk_In     (clk),
            .Rst_N      (rst_n),
            .Fifo_Empty (fifo_empty[gi]),
            .Fifo_Dout  (fifo_dout[gi]),
            .Fifo_Rd_En (fifo_rd_en[gi]),
            .Cmd_Hold   (cmd_hold),
            .Cmd        (cmd_w[gi]),
            .Cmd_En     (cmd_en[gi]),
            .Timeout_Err(to_err[gi]),
            .Cmd_Count  (cmd_cnt[gi])
        );
        assign fifo_empty[gi] = (rd_n[gi] >= wr_n);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read data is registered, valid the cycle after the pop.
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (fifo_rd_en[l]) begin
                fifo_dout[l] <= byte_mem[rd_n[l]];
                rd_n[l]      <= rd_n[l] + 1;
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
        end
    endfunction

    // Monitor: reset values, pop rules, event scoreboard and output stability.
    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst_n) begin
                chk($sformatf("rst_cmd_l%0d", l), cmd_w[l], 0);
                chk($sformatf("rst_en_l%0d", l), cmd_en[l], 0);
                chk($sformatf("rst_err_l%0d", l), to_err[l], 0);
                chk($sformatf("rst_cnt_l%0d", l), cmd_cnt[l], 0);
                chk($sformatf("rst_rd_l%0d", l), fifo_rd_en[l], 0);
                last_cmd[l] = 16'h0;
                last_cnt[l] = '0;
                prev_rd[l]  = 1'b0;
            end else begin
                if (fifo_rd_en[l]) begin
                    chk($sformatf("rd_when_empty_l%0d", l), fifo_empty[l], 0);
                    chk($sformatf("rd_back_to_back_l%0d", l), prev_rd[l], 0);
                    pop_cyc[l][pop_n[l]] = cyc;
                    pop_n[l]++;
                end
                prev_rd[l] = fifo_rd_en[l];
                if (cmd_en[l] || to_err[l]) begin
                    chk($sformatf("en_and_err_l%0d", l), cmd_en[l] & to_err[l], 0);
                    if (rd_ptr[l] >= exp_q.size()) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event_l%0d at cycle %0d: actual en=%0b err=%0b required none",
                                 l, cyc, cmd_en[l], to_err[l]);
                    end else begin
                        mon_ev = exp_q[rd_ptr[l]];
                        rd_ptr[l]++;
                        chk($sformatf("event_kind_l%0d", l), to_err[l], mon_ev.is_to);
                        mon_exp_c = pop_cyc[l][mon_ev.idx] + (mon_ev.is_to ? 9 : 2);
                        chk($sformatf("event_cycle_l%0d", l), cyc, mon_exp_c);
                        if (!mon_ev.is_to) begin
                            mon_val = (l == 0) ? mon_ev.v_hi : mon_ev.v_lo;
                            chk($sformatf("cmd_l%0d", l), cmd_w[l], mon_val);
                            chk($sformatf("count_l%0d", l), cmd_cnt[l], mon_ev.cnt);
                            last_cmd[l] = mon_val;
                            last_cnt[l] = mon_ev.cnt;
                        end else begin
                            chk($sformatf("to_cmd_kept_l%0d", l), cmd_w[l], last_cmd[l]);
                            chk($sformatf("to_count_kept_l%0d", l), cmd_cnt[l], last_cnt[l]);
                        end
                    end
                end else begin
                    chk($sformatf("cmd_stable_l%0d", l), cmd_w[l], last_cmd[l]);
                    chk($sformatf("count_stable_l%0d", l), cmd_cnt[l], last_cnt[l]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rtick(input int n);
        repeat (n) begin
            cmd_hold = ($urandom_range(0, 3) == 0);
            tick(1);
        end
    endtask

    task automatic push(input logic [7:0] b);
        byte_mem[wr_n] = b;
        wr_n++;
    endtask

    task automatic expect_cmd(input logic [7:0] b0, input logic [7:0] b1);
        ev_t e;
        model_cnt = model_cnt + 1'b1;
        e.is_to = 1'b0;
        e.v_hi  = {b0, b1};
        e.v_lo  = {b1, b0};
        e.cnt   = model_cnt;
        e.idx   = wr_n - 1;
        exp_q.push_back(e);
    endtask

    task automatic expect_to(input int idx);
        ev_t e;
        e.is_to = 1'b1;
        e.v_hi  = 16'h0;
        e.v_lo  = 16'h0;
        e.cnt   = model_cnt;
        e.idx   = idx;
        exp_q.push_back(e);
    endtask

    task automatic push_cmd(input logic [7:0] b0, input logic [7:0] b1);
        push(b0);
        push(b1);
        expect_cmd(b0, b1);
    endtask

    task automatic wait_popped(input string nm, input int idx);
        int n = 0;
        while (rd_n[0] <= idx && n < 50) begin
            tick(1);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL pop_%s: actual popped=%0d required=%0d", nm, rd_n[0], idx + 1);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (!(rd_n[0] == wr_n && rd_n[1] == wr_n &&
                 rd_ptr[0] == exp_q.size() && rd_ptr[1] == exp_q.size()) && n < 300) begin
            tick(1);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL drain_%s: actual pending=%0d/%0d required=0/0", nm,
                     exp_q.size() - rd_ptr[0], exp_q.size() - rd_ptr[1]);
        end
        tick(2);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: actual cycle=%0d required finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int i0;
        int i1;
        int n;
        logic [7:0] b0;
        logic [7:0] b1;

        rst_n     = 1'b0;
        cmd_hold  = 1'b0;
        model_cnt = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic pairs, including a zero byte.
        push_cmd(8'h12, 8'h34);
        drain("basic1");
        push_cmd(8'h01, 8'h00);
        drain("basic2");

        // Lone first byte times out, then the next pair assembles normally.
        push(8'hAB);
        expect_to(wr_n - 1);
        drain("timeout");
        push_cmd(8'h00, 8'h01);
        drain("after_timeout");

        // Byte arrives exactly on the timeout cycle: timeout wins, byte starts next command.
        push(8'h5A);
        i0 = wr_n - 1;
        expect_to(i0);
        n = 0;
        while (!(pop_n[0] > i0 && cyc == pop_cyc[0][i0] + 8) && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL edge_sync: actual cycle=%0d required pop+8", cyc);
        end
        push_cmd(8'hC3, 8'h3C);
        drain("timeout_edge");

        // Hold blocks the start of commands.
        cmd_hold = 1'b1;
        push_cmd(8'h55, 8'h55);
        push_cmd(8'hAA, 8'hAA);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("hold_rd_l0", fifo_rd_en[0], 0);
            chk("hold_rd_l1", fifo_rd_en[1], 0);
        end
        cmd_hold = 1'b0;
        drain("hold_release");

        // Hold rising mid-command does not stall completion.
        push(8'h81);
        wait_popped("hold_mid", wr_n - 1);
        cmd_hold = 1'b1;
        tick(2);
        push(8'h7E);
        expect_cmd(8'h81, 8'h7E);
        drain("hold_mid");
        cmd_hold = 1'b0;

        // Reset while the second byte is being read: nothing emitted.
        push(8'hDE);
        wait_popped("rst_b0", wr_n - 1);
        tick(2);
        push(8'hAD);
        i1 = wr_n - 1;
        wait_popped("rst_b1", i1);
        rst_n     = 1'b0;
        model_cnt = '0;
        push_cmd(8'hBE, 8'hEF);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("rst_hold_rd_l0", fifo_rd_en[0], 0);
            chk("rst_hold_rd_l1", fifo_rd_en[1], 0);
        end
        rst_n = 1'b1;
        drain("after_reset");

        // Randomised traffic with hold toggling; count wraps several times.
        for (int c = 0; c < 40; c++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            push(b0);
            rtick($urandom_range(0, 3));
            push(b1);
            expect_cmd(b0, b1);
            rtick($urandom_range(0, 2));
        end
        cmd_hold = 1'b0;
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
